// File: rtl/pulse_emitter_pkg.sv
// pulse_emitter_pkg
// Shared definitions for the pulse emitter: the FSM state encoding, the
// width of the HIGH/LOW width counter, and a helper that checks whether a
// cycle-count parameter fits in that counter.
package pulse_emitter_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_e;

    // A width parameter is usable when it is at least one cycle and still
    // fits in the 8-bit width counter.
    function automatic bit cycles_ok(input int n);
        return (n >= 1) && (n <= 255);
    endfunction

endpackage

// File: rtl/pulse_emitter_sat_counter.sv
// sat_counter
// Saturating up/down counter used as the pending-event queue depth.
//   clk, reset : clock and asynchronous active-high reset
//   inc_i      : request one increment this cycle
//   dec_i      : request one decrement this cycle (ignored when empty)
//   count_o    : current count (registered)
//   ovf_o      : strobe, high when an increment is dropped because the
//                counter is full and nothing is leaving this cycle
module sat_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [WIDTH-1:0] count_o,
    output logic             ovf_o
);

    localparam logic [WIDTH-1:0] MAX_COUNT = '1;

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             do_dec;
    logic             do_inc;

    always_comb begin
        do_dec  = dec_i && (count_q != '0);
        // A simultaneous decrement frees a slot, so a full counter still
        // accepts the increment in that case.
        ovf_o   = inc_i && (count_q == MAX_COUNT) && !do_dec;
        do_inc  = inc_i && !ovf_o;
        count_d = count_q;
        if (do_inc && !do_dec) begin
            count_d = count_q + 1'b1;
        end else if (do_dec && !do_inc) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pulse_emitter.sv
// pulse_emitter
// Turns single-cycle event strobes into stretched pulses of HIGH_CYCLES
// followed by at least LOW_CYCLES low, so that an edge-capturing receiver in
// a slower or unrelated clock domain can see every event. Events that arrive
// while a pulse is in flight are queued in a saturating counter.
//   clk, reset : clock and asynchronous active-high reset
//   event_in   : one request per cycle high
//   clear_ovf  : synchronous clear of the sticky overflow flag
//   pulse_out  : registered stretched pulse line
//   busy       : FSM is emitting (HIGH or LOW phase)
//   pending    : queued events not yet started
//   overflow   : sticky, an event was dropped because the queue was full
module pulse_emitter
    import pulse_emitter_pkg::*;
#(
    parameter int HIGH_CYCLES = 4,
    parameter int LOW_CYCLES  = 4,
    parameter int PEND_W      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              event_in,
    input  logic              clear_ovf,
    output logic              pulse_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    if (!cycles_ok(HIGH_CYCLES)) begin : g_bad_high
        $error("pulse_emitter: HIGH_CYCLES must be within 1..255");
    end
    if (!cycles_ok(LOW_CYCLES)) begin : g_bad_low
        $error("pulse_emitter: LOW_CYCLES must be within 1..255");
    end

    // The counter is loaded with N-1 and the phase ends when it reads zero,
    // giving exactly N cycles per phase.
    localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOW_LOAD  = CNT_W'(LOW_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pulse_q, pulse_d;
    logic              busy_q, busy_d;
    logic              overflow_q, overflow_d;
    logic              pend_dec;
    logic              pend_ovf;
    logic [PEND_W-1:0] pend_cnt;

    sat_counter #(
        .WIDTH (PEND_W)
    ) u_pending (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (event_in),
        .dec_i   (pend_dec),
        .count_o (pend_cnt),
        .ovf_o   (pend_ovf)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pulse_d  = pulse_q;
        pend_dec = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pend_cnt != '0) begin
                    state_d  = ST_HIGH;
                    cnt_d    = HIGH_LOAD;
                    pulse_d  = 1'b1;
                    pend_dec = 1'b1;
                end
            end
            ST_HIGH: begin
                if (cnt_q == '0) begin
                    state_d = ST_LOW;
                    cnt_d   = LOW_LOAD;
                    pulse_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_LOW: begin
                if (cnt_q == '0) begin
                    // Chain straight into the next pulse so back-to-back
                    // pulses keep a period of HIGH_CYCLES + LOW_CYCLES.
                    if (pend_cnt != '0) begin
                        state_d  = ST_HIGH;
                        cnt_d    = HIGH_LOAD;
                        pulse_d  = 1'b1;
                        pend_dec = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                pulse_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);

        // A drop on the same edge as a clear leaves the flag set.
        if (pend_ovf) begin
            overflow_d = 1'b1;
        end else if (clear_ovf) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            pulse_q    <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pulse_q    <= pulse_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
        end
    end

    assign pulse_out = pulse_q;
    assign busy      = busy_q;
    assign pending   = pend_cnt;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_pulse_emitter.sv
`timescale 1ns/1ps
module tb_pulse_emitter;

    localparam int H    = 4;
    localparam int L    = 4;
    localparam int PW   = 4;
    localparam int PMAX = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          clk2 = 1'b0;
    logic          reset = 1'b1;
    logic          event_in = 1'b0;
    logic          clear_ovf = 1'b0;
    logic          pulse_out;
    logic          busy;
    logic [PW-1:0] pending;
    logic          overflow;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;
    always #3.5 clk2 = ~clk2;

    pulse_emitter #(
        .HIGH_CYCLES (H),
        .LOW_CYCLES  (L),
        .PEND_W      (PW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .event_in  (event_in),
        .clear_ovf (clear_ovf),
        .pulse_out (pulse_out),
        .busy      (busy),
        .pending   (pending),
        .overflow  (overflow)
    );

    // ---------------- behavioural model ----------------
    // A pulse that started at edge S is high after edges S..S+H-1 and the
    // emitter is busy after edges S..S+H+L-1. A new pulse may start at any
    // edge at or after S+H+L when the queue holds something.
    int cyc     = 0;
    int m_now   = 0;
    int m_start = -1000;
    int m_pend  = 0;
    int m_acc   = 0;
    bit m_ovf   = 0;
    bit m_drop  = 0;

    int m_p;
    bit m_dec, m_take, m_drop_n, m_ovf_n;
    int m_start_n, m_pend_n;

    always_comb begin
        m_dec     = (cyc >= m_start + H + L) && (m_pend > 0);
        m_start_n = m_dec ? cyc : m_start;
        m_p       = m_pend - (m_dec ? 1 : 0);
        m_take    = event_in && (m_p < PMAX);
        m_drop_n  = event_in && !m_take;
        m_pend_n  = m_p + (m_take ? 1 : 0);
        m_ovf_n   = m_drop_n ? 1'b1 : (clear_ovf ? 1'b0 : m_ovf);
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_start <= -1000;
            m_pend  <= 0;
            m_ovf   <= 1'b0;
            m_drop  <= 1'b0;
            m_acc   <= 0;
        end else begin
            m_start <= m_start_n;
            m_pend  <= m_pend_n;
            m_ovf   <= m_ovf_n;
            m_drop  <= m_drop_n;
            m_acc   <= m_acc + (m_take ? 1 : 0);
            m_now   <= cyc;
            cyc     <= cyc + 1;
        end
    end

    function automatic int exp_pulse();
        return ((m_now >= m_start) && (m_now < m_start + H)) ? 1 : 0;
    endfunction

    function automatic int exp_busy();
        return ((m_now >= m_start) && (m_now < m_start + H + L)) ? 1 : 0;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- edge latch in an unrelated clock domain ----------------
    logic [2:0] sync2 = 3'b000;
    int         lat_cnt = 0;
    always @(posedge clk2) begin
        sync2 <= {sync2[1:0], pulse_out};
        if (sync2[1] && !sync2[2]) lat_cnt <= lat_cnt + 1;
    end

    // ---------------- per-cycle compare + rise monitor ----------------
    int rise_cyc[$];
    bit prev_pulse = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            chk("cyc_pulse", int'(pulse_out), exp_pulse());
            chk("cyc_busy", int'(busy), exp_busy());
            chk("cyc_pending", int'(pending), m_pend);
            chk("cyc_overflow", int'(overflow), int'(m_ovf));
            if (pulse_out && !prev_pulse) rise_cyc.push_back(m_now);
            prev_pulse = pulse_out;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int k = 0;
        while ((busy || pending != 0) && k < budget) begin
            tick();
            k++;
        end
        chk(nm, (busy || pending != 0) ? 1 : 0, 0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_acc, base_lat, k;
        bit seen;

        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("reset_pulse", int'(pulse_out), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_pending", int'(pending), 0);
        chk("reset_overflow", int'(overflow), 0);
        $display("phase reset: done");

        // single event
        event_in = 1'b1;
        tick();
        event_in = 1'b0;
        chk("single_pend_after_event", int'(pending), 1);
        chk("single_pulse_not_yet", int'(pulse_out), 0);
        tick();
        chk("single_pulse_rise", int'(pulse_out), 1);
        chk("single_pend_consumed", int'(pending), 0);
        chk("single_busy", int'(busy), 1);
        repeat (3) tick();
        chk("single_pulse_last_high", int'(pulse_out), 1);
        tick();
        chk("single_pulse_fall", int'(pulse_out), 0);
        chk("single_busy_in_low", int'(busy), 1);
        repeat (3) tick();
        chk("single_busy_last_low", int'(busy), 1);
        tick();
        chk("single_busy_drop", int'(busy), 0);
        $display("phase single event: done");

        // three consecutive events
        rise_cyc.delete();
        event_in = 1'b1;
        repeat (3) tick();
        event_in = 1'b0;
        wait_idle("triple_drain_timeout", 100);
        chk("triple_pulse_count", rise_cyc.size(), 3);
        if (rise_cyc.size() == 3) begin
            chk("triple_period_1", rise_cyc[1] - rise_cyc[0], H + L);
            chk("triple_period_2", rise_cyc[2] - rise_cyc[1], H + L);
        end
        $display("phase three events: done");

        // saturation
        rise_cyc.delete();
        base_acc = m_acc;
        k = 0;
        event_in = 1'b1;
        while (!m_ovf && k < 60) begin
            tick();
            k++;
        end
        chk("sat_overflow", int'(overflow), 1);
        chk("sat_pending", int'(pending), PMAX);

        // clear on the same edge as a drop: drop wins
        seen = 1'b0;
        k = 0;
        clear_ovf = 1'b1;
        while (!seen && k < 40) begin
            tick();
            seen = m_drop;
            k++;
        end
        chk("clr_drop_seen", int'(seen), 1);
        chk("clr_with_drop_overflow", int'(overflow), 1);
        event_in = 1'b0;
        tick();
        clear_ovf = 1'b0;
        chk("clr_alone_overflow", int'(overflow), 0);
        wait_idle("sat_drain_timeout", 400);
        chk("sat_pulses_vs_accepted", rise_cyc.size(), m_acc - base_acc);
        $display("phase saturation: accepted %0d pulses %0d", m_acc - base_acc, rise_cyc.size());

        // reset mid-pulse
        event_in = 1'b1;
        repeat (3) tick();
        event_in = 1'b0;
        chk("rst_mid_pulse_high", int'(pulse_out), 1);
        chk("rst_mid_pending", int'(pending), 2);
        #2 reset = 1'b1;
        #1;
        chk("rst_async_pulse", int'(pulse_out), 0);
        chk("rst_async_pending", int'(pending), 0);
        chk("rst_async_busy", int'(busy), 0);
        tick();
        #2 reset = 1'b0;
        rise_cyc.delete();
        repeat (20) tick();
        chk("rst_no_pulse_after", rise_cyc.size(), 0);
        event_in = 1'b1;
        tick();
        event_in = 1'b0;
        tick();
        chk("rst_first_event_rise", int'(pulse_out), 1);
        wait_idle("rst_drain_timeout", 100);
        $display("phase reset mid-pulse: done");

        // randomized events with loopback into the foreign-clock latch
        repeat (5) tick();
        rise_cyc.delete();
        base_acc = m_acc;
        base_lat = lat_cnt;
        k = 0;
        while ((m_acc - base_acc) < 200 && k < 20000) begin
            event_in  = ($urandom_range(0, 3) == 0);
            clear_ovf = ($urandom_range(0, 31) == 0);
            tick();
            k++;
        end
        event_in  = 1'b0;
        clear_ovf = 1'b0;
        chk("rand_event_budget", ((m_acc - base_acc) >= 200) ? 1 : 0, 1);
        wait_idle("rand_drain_timeout", 400);
        repeat (5) tick();
        chk("rand_pulses_vs_accepted", rise_cyc.size(), m_acc - base_acc);
        chk("rand_latch_vs_accepted", lat_cnt - base_lat, m_acc - base_acc);
        $display("phase random: accepted %0d latch strobes %0d", m_acc - base_acc, lat_cnt - base_lat);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
